// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_CLEAR = 2'd1,
        RF_DONE  = 2'd2
    } rf_state_e;

    localparam int RF_MAX_RD = 4;

    function automatic int rfDepth(input int addrW);
        return 1 << addrW;
    endfunction

    function automatic int rfBytes(input int dataW);
        return dataW / 8;
    endfunction

endpackage

// File: rtl/rf_byte_merge.sv
// Combinational byte merge: enabled bytes come from newData_i, the rest from oldData_i.
module rf_byte_merge
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   oldData_i,
    input  logic [DATA_W-1:0]   newData_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   merged_o
);

    localparam int N_BYTES = rfBytes(DATA_W);

    for (genvar k = 0; k < N_BYTES; k++) begin : gByte
        assign merged_o[k*8 +: 8] = be_i[k] ? newData_i[k*8 +: 8] : oldData_i[k*8 +: 8];
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: N_RD combinational read ports, one byte-enabled write port,
// optional write-to-read bypass and a one-entry-per-cycle background clear sequencer.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk_Regs,
    input  logic                     rst,
    input  logic                     Reg_Write,
    input  logic [ADDR_W-1:0]        W_Addr,
    input  logic [DATA_W-1:0]        W_Data,
    input  logic [DATA_W/8-1:0]      W_Be,
    input  logic [N_RD*ADDR_W-1:0]   R_Addr,
    output logic [N_RD*DATA_W-1:0]   R_Data,
    input  logic                     Clr_Req,
    output logic                     Clr_Busy,
    output logic                     Clr_Done
);

    localparam int DEPTH = rfDepth(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;
    logic              clrEn;

    logic              zeroWrite;
    logic              wrEn;
    logic              fwdEn;
    logic [DATA_W-1:0] wrMerged;

    // Writes only land while idle; the zero register silently swallows them.
    assign zeroWrite = (ZERO_REG != 0) && (W_Addr == '0);
    assign wrEn      = Reg_Write && (state_q == RF_IDLE) && !zeroWrite;
    assign fwdEn     = (BYPASS != 0) && wrEn;

    // The merged word serves both the array write and every bypassed read port.
    rf_byte_merge #(
        .DATA_W(DATA_W)
    ) uMerge (
        .oldData_i(mem_q[W_Addr]),
        .newData_i(W_Data),
        .be_i     (W_Be),
        .merged_o (wrMerged)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        clrEn   = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if (Clr_Req) begin
                    state_d = RF_CLEAR;
                    ptr_d   = '0;
                end
            end
            RF_CLEAR: begin
                clrEn = 1'b1;
                if (ptr_q == '1) begin
                    state_d = RF_DONE;
                    ptr_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            RF_DONE: begin
                if (!Clr_Req) begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                state_d = RF_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_Regs) begin
        if (rst) begin
            state_q <= RF_IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // Reset zeroes the whole array in one edge; the sweep has priority over a (blocked) write.
    always_ff @(posedge clk_Regs) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clrEn) begin
            mem_q[ptr_q] <= '0;
        end else if (wrEn) begin
            mem_q[W_Addr] <= wrMerged;
        end
    end

    for (genvar p = 0; p < N_RD; p++) begin : gRead
        logic [ADDR_W-1:0] rAddr;
        logic [DATA_W-1:0] rVal;

        assign rAddr = R_Addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            rVal = mem_q[rAddr];
            if (fwdEn && (rAddr == W_Addr)) begin
                rVal = wrMerged;
            end
            if (rst || ((ZERO_REG != 0) && (rAddr == '0))) begin
                rVal = '0;
            end
        end

        assign R_Data[p*DATA_W +: DATA_W] = rVal;
    end

    assign Clr_Busy = (state_q == RF_CLEAR) && !rst;
    assign Clr_Done = done_q && !rst;

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file: the successor to the team's fixed 32×32, 2-read-port register file. It serves the CPU datapath (ID-stage operand fetch, WB-stage writeback) and adds:
- configurable width, depth and read-port count;
- byte-enabled synchronous writes;
- optional write-to-read bypass;
- a handshaked background clear sequencer that zeroes the array one entry per cycle without a reset.

## Interface
- DATA_W, 32: data width in bits, a multiple of 8.
- ADDR_W, 5: address width; depth is 2^ADDR_W entries.
- N_RD, 2: number of read ports, 1..4.
- ZERO_REG, 1: when 1, entry 0 reads as 0 and ignores writes.
- BYPASS, 1: when 1, a same-cycle write to an address being read is forwarded to that read port.
- clk_Regs  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- Reg_Write  in  1  write enable.
- W_Addr  in  ADDR_W  write address.
- W_Data  in  DATA_W  write data.
- W_Be  in  DATA_W/8  byte enables; bit k gates W_Data[8k+7:8k].
- R_Addr  in  N_RD*ADDR_W  packed read addresses; port p uses slice [p*ADDR_W +: ADDR_W].
- R_Data  out  N_RD*DATA_W  packed read data, same packing as R_Addr.
- Clr_Req  in  1  request a full clear (level).
- Clr_Busy  out  1  clear sweep in progress.
- Clr_Done  out  1  one-cycle pulse when the sweep completes.

## Operation
- Storage: 2^ADDR_W × DATA_W array, written only on the clock edge. No combinational writes.
- Write: if Reg_Write and the FSM is IDLE, then for each k with W_Be[k]=1, entry[W_Addr] byte k takes W_Data byte k. Other bytes hold their value.
- ZERO_REG=1: writes to address 0 are dropped; reads of address 0 return 0 regardless of BYPASS.
- Read: R_Data port p is combinational from entry[R_Addr_p].
- Bypass (BYPASS=1): a port is forwarded when Reg_Write=1, the FSM is IDLE, R_Addr_p == W_Addr, and the address is not zero-forced. A forwarded port returns the byte-merged value:
  - enabled bytes come from W_Data;
  - disabled bytes come from the stored entry.
- BYPASS=0: reads return the pre-edge contents.
- Clear FSM states:
  - IDLE: Clr_Req=1 moves to CLEAR with ptr=0.
  - CLEAR: each cycle writes entry[ptr]=0 and increments ptr. When ptr = 2^ADDR_W−1, zero that last entry, pulse Clr_Done, and move to DONE.
  - DONE: wait for Clr_Req=0, then go to IDLE. A held Clr_Req does not restart the sweep.
- During CLEAR, Reg_Write is ignored (the write is lost) and reads return current array contents. There is no forwarding during CLEAR.
- Reset: rst=1 at an edge zeroes every entry in that cycle and forces the FSM to IDLE with ptr=0. Reset mid-sweep aborts the sweep; no Clr_Done is issued.
- Output values during/after reset: Clr_Busy=0, Clr_Done=0, and every R_Data port reads 0.
- ptr is ADDR_W bits wide. The terminal comparison is on all-ones, so ptr never wraps inside a sweep.

## Timing
- Write latency: 1 cycle; visible on a non-bypassed read the cycle after the edge.
- Read latency: 0 cycles (combinational).
- Clear duration: Clr_Busy rises the cycle after Clr_Req is sampled high and stays high for exactly 2^ADDR_W cycles (32 at default).
- Clr_Done asserts in the cycle after the last entry is zeroed, for exactly 1 cycle; Clr_Busy=0 in that cycle.
- Simultaneous rst and Clr_Req: rst wins; the FSM is IDLE next cycle.
- Simultaneous Reg_Write and the IDLE→CLEAR transition edge: the write commits (the FSM was still IDLE), then the sweep zeroes it.

## Structure
- Shared package regfile_pkg holds:
  - the FSM state enum RF_IDLE / RF_CLEAR / RF_DONE;
  - localparam helpers for depth (1<<ADDR_W) and byte count (DATA_W/8).
- One natural sub-module, rf_byte_merge: combinational merge of old data, new data and byte enables. It is shared by the write path and the bypass path.
- The read ports are generated by a generate loop over N_RD.

## Test plan
- After reset, write 0xDEADBEEF to address 5 with W_Be=4'hF; next cycle R_Addr port0=5 -> 0xDEADBEEF, and port1=0 -> 0.
- With entry 5 = 0xDEADBEEF, write 0x11223344 with W_Be=4'b0101 while reading address 5 with BYPASS=1 -> 0xDE22BE44 in the same cycle and after the edge. With BYPASS=0 -> 0xDEADBEEF in the same cycle, 0xDE22BE44 after the edge.
- Write 0xFFFFFFFF to address 0 -> all ports read 0. With ZERO_REG=0, the same write reads back 0xFFFFFFFF.
- Fill all 32 entries with nonzero values, pulse Clr_Req for 1 cycle -> Clr_Busy high for 32 cycles, then a Clr_Done pulse of 1 cycle; all entries read 0. A write issued mid-sweep does not land.
- Assert rst 10 cycles into a sweep -> next cycle Clr_Busy=0, no Clr_Done, all entries 0. Holding Clr_Req high through DONE gives a single sweep only.
- With N_RD=4, DATA_W=64, ADDR_W=3: 4 ports read distinct addresses with the correct packing; the sweep lasts 8 cycles.
